// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller (master) reads OpCode and drives State plus all control strobes.
interface mips_multicycle_ctrl_if;
  logic [5:0] OpCode;
  logic [2:0] State;
  logic       RegDst;
  logic       Branch;
  logic       MemRead;
  logic       MemtoReg;
  logic [1:0] ALUOp;
  logic       MemWrite;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic       PCWrite;
  logic       IRWrite;

  modport master (
    input  OpCode,
    output State, RegDst, Branch, MemRead, MemtoReg, ALUOp,
           MemWrite, ALUSrc, RegWrite, Jump, PCWrite, IRWrite
  );

  modport slave (
    output OpCode,
    input  State, RegDst, Branch, MemRead, MemtoReg, ALUOp,
           MemWrite, ALUSrc, RegWrite, Jump, PCWrite, IRWrite
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: five-state instruction FSM plus opcode decode.
// Only the state is registered; every strobe is combinational from OpCode/State.
module mips_multicycle_ctrl (
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  logic       dec_reg_dst, dec_branch, dec_mem_read, dec_mem_to_reg;
  logic       dec_mem_write, dec_alu_src, dec_reg_write, dec_jump;
  logic [1:0] dec_alu_op;
  logic       dec_en, pc_write, ir_write;

  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_op     = 2'b00;
    case (bus.OpCode)
      OP_RTYPE: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu_op = 2'b01;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_J:    dec_jump = 1'b1;
      default: ;
    endcase
  end

  // PCWrite fires in whichever state turns out to be the instruction's last.
  always_comb begin
    state_d  = S_FETCH;
    dec_en   = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        dec_en  = 1'b1;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        dec_en = 1'b1;
        if (dec_mem_read || dec_mem_write) begin
          state_d = S_MEMORY;
        end else if (dec_reg_write) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_write = 1'b1;
        end
      end
      S_MEMORY: begin
        dec_en = 1'b1;
        if (dec_reg_write) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_write = 1'b1;
        end
      end
      S_WRITEBACK: begin
        dec_en   = 1'b1;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      dec_en   = 1'b0;
      pc_write = 1'b0;
      ir_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.State    = state_q;
  assign bus.RegDst   = dec_en & dec_reg_dst;
  assign bus.Branch   = dec_en & dec_branch;
  assign bus.MemRead  = dec_en & dec_mem_read;
  assign bus.MemtoReg = dec_en & dec_mem_to_reg;
  assign bus.ALUOp    = dec_en ? dec_alu_op : 2'b00;
  assign bus.MemWrite = dec_en & dec_mem_write;
  assign bus.ALUSrc   = dec_en & dec_alu_src;
  assign bus.RegWrite = dec_en & dec_reg_write;
  assign bus.Jump     = dec_en & dec_jump;
  assign bus.PCWrite  = pc_write;
  assign bus.IRWrite  = ir_write;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a vector table of per-cycle
// expectations followed by instruction-length measurements.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output packing: {RegDst,Branch,MemRead,MemtoReg}_{ALUOp}_{MemWrite,ALUSrc,RegWrite,Jump}_{PCWrite,IRWrite}
  localparam logic [11:0] ZERO = 12'b0000_00_0000_00;
  localparam logic [11:0] FTCH = 12'b0000_00_0000_01;
  localparam logic [11:0] R_M  = 12'b1000_10_0010_00;
  localparam logic [11:0] R_F  = 12'b1000_10_0010_10;
  localparam logic [11:0] LW_M = 12'b0011_00_0110_00;
  localparam logic [11:0] LW_F = 12'b0011_00_0110_10;
  localparam logic [11:0] SW_M = 12'b0000_00_1100_00;
  localparam logic [11:0] SW_F = 12'b0000_00_1100_10;
  localparam logic [11:0] BQ_M = 12'b0100_01_0000_00;
  localparam logic [11:0] BQ_F = 12'b0100_01_0000_10;
  localparam logic [11:0] J_M  = 12'b0000_00_0001_00;
  localparam logic [11:0] J_F  = 12'b0000_00_0001_10;
  localparam logic [11:0] NOPM = 12'b0000_00_0000_00;
  localparam logic [11:0] NOPF = 12'b0000_00_0000_10;
  localparam logic [11:0] AD_M = 12'b0000_00_0110_00;
  localparam logic [11:0] AD_F = 12'b0000_00_0110_10;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic [2:0]  st;
    logic [11:0] outs;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] outs_now();
    return {bus.RegDst, bus.Branch, bus.MemRead, bus.MemtoReg, bus.ALUOp,
            bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.Jump, bus.PCWrite, bus.IRWrite};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic [2:0] s, input logic [11:0] e);
    vec_t v;
    v.rst = r; v.opc = o; v.st = s; v.outs = e;
    vecs.push_back(v);
  endtask

  // Cycles from release of reset (FETCH) through the PCWrite cycle, inclusive.
  task automatic measure(input logic [5:0] opc, input int exp_cycles, input string name);
    int n;
    bit seen;
    @(negedge clk);
    reset = 1'b1;
    bus.OpCode = opc;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      n++;
      if (bus.PCWrite) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!seen || n != exp_cycles) begin
      fails++;
      $display("FAIL len_%s: got %0d cycles (pcwrite_seen=%0b), want %0d", name, n, seen, exp_cycles);
    end else begin
      $display("[TB] len_%s: %0d cycles ok", name, n);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.OpCode = OP_R;

    add(1, OP_R,   0, ZERO);
    add(1, OP_R,   0, ZERO);
    add(0, OP_BAD, 0, FTCH);   // junk opcode during FETCH must be masked
    add(0, OP_R,   1, R_M);
    add(0, OP_R,   2, R_M);
    add(0, OP_R,   4, R_F);
    add(0, OP_LW,  0, FTCH);
    add(0, OP_LW,  1, LW_M);
    add(0, OP_LW,  2, LW_M);
    add(0, OP_LW,  3, LW_M);
    add(0, OP_LW,  4, LW_F);
    add(0, OP_SW,  0, FTCH);
    add(0, OP_SW,  1, SW_M);
    add(0, OP_SW,  2, SW_M);
    add(0, OP_SW,  3, SW_F);
    add(0, OP_BEQ, 0, FTCH);
    add(0, OP_BEQ, 1, BQ_M);
    add(0, OP_BEQ, 2, BQ_F);
    add(0, OP_J,   0, FTCH);
    add(0, OP_J,   1, J_M);
    add(0, OP_J,   2, J_F);
    add(0, OP_BAD, 0, FTCH);
    add(0, OP_BAD, 1, NOPM);
    add(0, OP_BAD, 2, NOPF);
    add(0, OP_ADD, 0, FTCH);
    add(0, OP_ADD, 1, AD_M);
    add(0, OP_ADD, 2, AD_M);
    add(0, OP_ADD, 4, AD_F);
    add(0, OP_LW,  0, FTCH);
    add(0, OP_LW,  1, LW_M);
    add(0, OP_LW,  2, LW_M);
    add(1, OP_LW,  3, ZERO);   // reset lands while lw is in MEMORY
    add(1, OP_LW,  0, ZERO);
    add(0, OP_LW,  0, FTCH);
    add(0, OP_LW,  1, LW_M);

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      bus.OpCode = vecs[i].opc;
      #1;
      tests++;
      if (bus.State !== vecs[i].st) begin
        fails++;
        $display("FAIL vec%0d_state: got %0d, want %0d", i, bus.State, vecs[i].st);
      end
      tests++;
      if (outs_now() !== vecs[i].outs) begin
        fails++;
        $display("FAIL vec%0d_outs: got %b, want %b (state %0d)", i, outs_now(), vecs[i].outs, bus.State);
      end
      $display("[TB] vec%0d rst=%0b op=%b state=%0d outs=%b", i, vecs[i].rst, vecs[i].opc, bus.State, outs_now());
    end

    measure(OP_LW,  5, "lw");
    measure(OP_SW,  4, "sw");
    measure(OP_R,   4, "rtype");
    measure(OP_ADD, 4, "addi");
    measure(OP_BEQ, 3, "beq");
    measure(OP_J,   3, "j");
    measure(OP_BAD, 3, "nop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
